// File: rtl/rv32_memory_pkg.sv
// Shared types for the core's memory read path: data width, arbiter FSM states
// and requester identifiers.
package rv32_memory_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESPOND
  } memory_arbiter_state_t;

  typedef enum logic {
    FETCH = 1'b0,
    LOAD  = 1'b1
  } requester_id_t;

endpackage

// File: rtl/memory_arbiter_select.sv
// Combinational winner selection between fetch and load.
// MEMORY_READ_ARBITER_ROUND_ROBIN_EN: alternate on ties; otherwise load always wins.
module memory_arbiter_select
  import rv32_memory_pkg::*;
(
  input  logic          fetch_request,
  input  logic          load_request,
`ifdef MEMORY_READ_ARBITER_ROUND_ROBIN_EN
  input  requester_id_t last_grant,
`endif
  output logic          grant_valid,
  output requester_id_t winner
);

  assign grant_valid = fetch_request | load_request;

  // NOTE: winner is assigned on every path, so this block cannot infer a latch.
  always_comb begin
    winner = FETCH;
`ifdef MEMORY_READ_ARBITER_ROUND_ROBIN_EN
    if (fetch_request && load_request) begin
      winner = (last_grant == FETCH) ? LOAD : FETCH;
    end else if (load_request) begin
      winner = LOAD;
    end
`else
    if (load_request) begin
      winner = LOAD;
    end
`endif
  end

endmodule

// File: rtl/memory_read_arbiter.sv
// Shares one memory read port between fetch and load with a fixed-latency FSM.
// MEMORY_READ_ARBITER_ROUND_ROBIN_EN selects round-robin tie breaking.
module memory_read_arbiter
  import rv32_memory_pkg::*;
#(
  parameter int unsigned MEMORY_LATENCY = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            fetch_request,
  input  logic [XLEN-1:0] fetch_address,
  output logic            fetch_ready,
  output logic [XLEN-1:0] fetch_data,
  input  logic            load_request,
  input  logic [XLEN-1:0] load_address,
  output logic            load_ready,
  output logic [XLEN-1:0] load_data,
  output logic            read_enable,
  output logic [XLEN-1:0] memory_read_address,
  input  logic [XLEN-1:0] memory_read_value
);

  localparam logic [3:0] LATENCY_INIT = 4'(MEMORY_LATENCY);

  memory_arbiter_state_t state, next_state;
  requester_id_t         winner, winner_q;
  logic                  grant_valid;
  logic [XLEN-1:0]       address_q;
  logic [XLEN-1:0]       fetch_data_q;
  logic [XLEN-1:0]       load_data_q;
  logic [3:0]            count_q;

`ifdef MEMORY_READ_ARBITER_ROUND_ROBIN_EN
  requester_id_t last_grant;

  // Reset to LOAD so that fetch wins the first tie after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= LOAD;
    end else if (state == IDLE && grant_valid) begin
      last_grant <= winner;
    end
  end
`endif

  memory_arbiter_select u_select (
    .fetch_request (fetch_request),
    .load_request  (load_request),
`ifdef MEMORY_READ_ARBITER_ROUND_ROBIN_EN
    .last_grant    (last_grant),
`endif
    .grant_valid   (grant_valid),
    .winner        (winner)
  );

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (grant_valid) next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    if (count_q == 4'd1) next_state = RESPOND;
      RESPOND: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      winner_q     <= FETCH;
      address_q    <= '0;
      count_q      <= '0;
      fetch_data_q <= '0;
      load_data_q  <= '0;
    end else begin
      state <= next_state;
      unique case (state)
        IDLE: begin
          if (grant_valid) begin
            winner_q  <= winner;
            address_q <= (winner == LOAD) ? load_address : fetch_address;
          end
        end
        ISSUE: count_q <= LATENCY_INIT;
        WAIT: begin
          count_q <= count_q - 4'd1;
          // The memory word is valid only in the cycle the count reaches 1.
          if (count_q == 4'd1) begin
            if (winner_q == LOAD) load_data_q  <= memory_read_value;
            else                  fetch_data_q <= memory_read_value;
          end
        end
        default: ;
      endcase
    end
  end

  assign read_enable         = (state == ISSUE);
  assign memory_read_address = address_q;
  assign fetch_ready         = (state == RESPOND) && (winner_q == FETCH);
  assign load_ready          = (state == RESPOND) && (winner_q == LOAD);
  assign fetch_data          = fetch_data_q;
  assign load_data           = load_data_q;

endmodule

// File: doc/memory_read_arbiter.md
# memory_read_arbiter

Shares the core's single memory read port between instruction fetch (driven by `pc`) and the data-load path of the execute stage. Each requester uses a level request/ready handshake. The arbiter grants one requester at a time and drives `read_enable` and `memory_read_address`. It waits a fixed memory latency, captures `memory_read_value`, and returns the word to the winner with a one-cycle `ready` pulse. It sits between fetch/execute and the memory model, replacing their direct connection to the read port.

## Interface
- `XLEN`, 32: data and address width.
- `MEMORY_LATENCY`, 1: cycles from the `read_enable` cycle to the cycle `memory_read_value` is valid; legal range 1..15.

Ports:
- `clock`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `fetch_request`  in  1  fetch wants a word; level, held with a stable address until served.
- `fetch_address`  in  XLEN  fetch byte address.
- `fetch_ready`  out  1  one-cycle pulse; `fetch_data` valid.
- `fetch_data`  out  XLEN  returned instruction word.
- `load_request`  in  1  load wants a word; same rules as fetch.
- `load_address`  in  XLEN  load byte address.
- `load_ready`  out  1  one-cycle pulse; `load_data` valid.
- `load_data`  out  XLEN  returned data word.
- `read_enable`  out  1  memory read strobe.
- `memory_read_address`  out  XLEN  address to memory.
- `memory_read_value`  in  XLEN  memory read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - Otherwise choose a winner, register the winner id and its address, and go to ISSUE.
- **ISSUE**: `read_enable`=1 and `memory_read_address` = latched address for exactly one cycle. Load the latency counter with `MEMORY_LATENCY`. Go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - In the cycle the counter reaches 1, `memory_read_value` is valid. Capture it into the winner's data register and go to RESPOND.
- **RESPOND**
  - Assert the winner's `*_ready` for one cycle and go to IDLE.
  - `*_data` holds its value until the next capture for that requester.
- Requester rule:
  - On the edge that ends its ready cycle, a requester either drops its request or presents a new address.
  - A request high in IDLE is always treated as new.
- Requests that arrive in non-IDLE states are not lost. They are level-held and sampled at the next IDLE.
- Addresses are passed through unmodified: no alignment check, no width change.
- Arbitration policy is selected by the configuration macro.

## Timing
- Reset values:
  - State IDLE.
  - `read_enable`, `fetch_ready`, `load_ready` = 0.
  - `memory_read_address`, `fetch_data`, `load_data` = 0.
  - Last-grant register = load.
- Request seen in IDLE at cycle N:
  - `read_enable` in cycle N+1.
  - Data sampled in cycle N+1+MEMORY_LATENCY.
  - `*_ready` in cycle N+2+MEMORY_LATENCY.
  - Back in IDLE at N+3+MEMORY_LATENCY.
- Throughput: one access per MEMORY_LATENCY+3 cycles.
- Only one `*_ready` is high in any cycle, never both.
- Reset asserted in any state:
  - Next cycle is IDLE with all outputs at their reset values.
  - The in-flight access is abandoned; its data is never delivered, and late memory data is ignored.
- Both requests high in the same IDLE cycle: resolved per Configuration; the loser stays pending.

## Configuration
- Macro: `MEMORY_READ_ARBITER_ROUND_ROBIN_EN`.
- Defined: on a tie, grant the requester not in the last-grant register. Update the register on every grant. After reset, fetch wins the first tie.
- Undefined: fixed priority, load always beats fetch. The last-grant register is not implemented.

## Structure
- Shared package `rv32_memory_pkg`:
  - `XLEN` constant.
  - `memory_arbiter_state_t` enum (IDLE/ISSUE/WAIT/RESPOND).
  - `requester_id_t` (FETCH, LOAD).
- One sub-module, `memory_arbiter_select`: combinational winner selection from the two requests, the last grant, and the macro.
- The FSM, latency counter and capture registers stay in the top module.

## Test plan
- Reset, then fetch only, `fetch_address`=0x0000_0010, memory returns 0x0050_0093, `MEMORY_LATENCY`=1. Expect: `read_enable` at N+1 with address 0x10; `fetch_ready`=1 with `fetch_data`=0x0050_0093 at N+3; `load_ready` stays 0.
- `MEMORY_LATENCY`=3, load only, address 0x0000_0100, memory returns 0xDEAD_BEEF. Expect: `load_ready` at N+5 with `load_data`=0xDEAD_BEEF.
- Both requests high at N:
  - Macro undefined: load is served at N+3 and fetch at N+7.
  - Macro defined: fetch is served first, and on the second tie load wins.
- Fetch held high continuously with addresses 0x0, 0x4, 0x8, each advanced on the ready edge, `MEMORY_LATENCY`=1. Expect: three `fetch_ready` pulses 4 cycles apart and `read_enable` exactly three times.
- `reset` pulsed in WAIT. Expect: no `*_ready` for the abandoned access, outputs 0 the next cycle, and a new request served with normal latency.
